trigger_seq: RTL and testbench
==============================

Name: trigger_seq

Overview:
Multi-probe, arm-able trigger sequencer for the logic-analyzer capture path. Each of NUM_PROBES channels evaluates a per-channel compare op (same 4-bit op encoding as the single-probe trigger). Channel results are combined by AND or OR. The block fires a registered one-cycle trig pulse after the combined condition has held on COUNT_TARGET qualifying cycles while armed. It sits between the probe taps and the sample-memory write controller, and its status is readable over the register bus.

Parameters:
INPUT_WIDTH, 8, width of each probe and each argument
NUM_PROBES, 4, number of independent compare channels (1..16)
COUNT_WIDTH, 16, width of occurrence counter and count_target

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
probes  input  NUM_PROBES*INPUT_WIDTH  probe vectors; channel i = bits [i*INPUT_WIDTH +: INPUT_WIDTH]
ops  input  NUM_PROBES*4  per-channel op; channel i = bits [i*4 +: 4]
args  input  NUM_PROBES*INPUT_WIDTH  per-channel compare argument
mode  input  1  0 = OR of enabled channels, 1 = AND of enabled channels
count_target  input  COUNT_WIDTH  qualifying cycles required to fire; 0 treated as 1
arm  input  1  single-cycle pulse: enter ARMED and clear counter
disarm  input  1  single-cycle pulse: return to IDLE
trig  output  1  one-cycle fire pulse
armed  output  1  high in ARMED
triggered  output  1  sticky; high in FIRED
hit_count  output  COUNT_WIDTH  current occurrence count

Behaviour:
- Op encoding per channel: 0 DISABLE, 1 RISING (p>prev), 2 FALLING (p<prev), 3 CHANGING (p!=prev), 4 GT, 5 LT, 6 GEQ, 7 LEQ, 8 EQ, 9 NEQ (vs arg). Codes 10-15 behave as DISABLE. All compares are unsigned.
- Per-channel prev register holds the probe value from the previous cycle. prev_valid is cleared by reset and set after the first clock.
- While prev_valid=0, RISING/FALLING/CHANGING evaluate false.
- A channel is enabled iff its op is 1..9.
- Combined condition cond: OR mode = OR of enabled channel results. AND mode = AND of enabled channel results.
- If no channel is enabled, cond = 0 in both modes.
- States: IDLE, ARMED, FIRED.
- IDLE: arm -> ARMED, hit_count <= 0.
- ARMED, cond=1: hit_count increments, saturating at all-ones. When hit_count+1 >= max(count_target,1), go to FIRED and trig=1 for exactly one cycle. trig is registered, so it is high the cycle after the qualifying sample edge.
- ARMED, cond=0: hit_count holds. Qualifying cycles need not be consecutive.
- FIRED: triggered=1; trig stays 0; hit_count frozen. arm -> ARMED with count cleared.
- disarm in any state -> IDLE; hit_count holds its value.
- arm and disarm in the same cycle: disarm wins.
- arm while ARMED: restarts, hit_count <= 0. If cond=1 in that same cycle, it is not counted.
- count_target changed while ARMED takes effect on the next compare. If hit_count already meets the new target, the next qualifying cycle fires.
- Reset: state IDLE; trig=0, armed=0, triggered=0, hit_count=0, prev registers=0, prev_valid=0. Reset asserted mid-ARMED aborts with no trig pulse.
- Outputs armed and triggered are decoded from registered state. No combinational path from probes to any output.

Test Plan:
- Reset, NUM_PROBES=4, ch0 op=8 arg=0x5A, others 0, mode=0, count_target=1. Arm; drive ch0=0x5A at cycle N -> trig=1 at N+1 only; triggered=1, armed=0, hit_count=1.
- AND mode, ch0 GT arg=0x10, ch1 FALLING. Drive ch0=0x20 and ch1 0x08->0x03 -> fires. Same stimulus with ch0=0x10 -> no trig.
- count_target=3, ch0 EQ 0x01, probe pattern 1,0,1,0,1 -> hit_count 1,1,2,2,3; trig on the cycle after the third match.
- count_target=0 behaves as 1. All ops DISABLE, arm, 20 cycles of random probes -> trig never asserts, hit_count=0.
- ch0 RISING; first cycle after reset with probe=0xFF -> no hit (prev_valid=0). Then 0xFF->0xFF no hit; 0xFF->0x00->0x01 -> hit.
- Simultaneous arm+disarm -> IDLE. Arm, 1 match of 3, then reset asserted -> all outputs 0, no trig. arm in FIRED -> ARMED, hit_count=0.

Source files
------------

// File: rtl/trigger_seq_if.sv
// trigger_seq bus bundle: probe taps, compare setup,
// arm/disarm control and status back to the capture path.
interface trigger_seq_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int NUM_PROBES  = 4,
  parameter int COUNT_WIDTH = 16
) ();

  logic [NUM_PROBES*INPUT_WIDTH-1:0] probes;
  logic [NUM_PROBES*4-1:0]           ops;
  logic [NUM_PROBES*INPUT_WIDTH-1:0] args;
  logic                              mode;
  logic [COUNT_WIDTH-1:0]            count_target;
  logic                              arm;
  logic                              disarm;
  logic                              trig;
  logic                              armed;
  logic                              triggered;
  logic [COUNT_WIDTH-1:0]            hit_count;

  modport master (
    output probes, ops, args, mode,
    output count_target, arm, disarm,
    input  trig, armed, triggered, hit_count
  );

  modport slave (
    input  probes, ops, args, mode,
    input  count_target, arm, disarm,
    output trig, armed, triggered, hit_count
  );

endinterface

// File: rtl/trigger_seq.sv
// Multi-probe arm-able trigger sequencer: per-channel
// compares, AND/OR combine, counted one-cycle fire pulse.
module trigger_seq #(
  parameter int INPUT_WIDTH = 8,
  parameter int NUM_PROBES  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  trigger_seq_if.slave bus
);

  localparam int W  = INPUT_WIDTH;
  localparam int N  = NUM_PROBES;
  localparam int CW = COUNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FIRED
  } state_t;

  state_t          state;
  logic [N*W-1:0]  prev;
  logic            prev_valid;
  logic            trig_q;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    en;
  logic [N-1:0]    hit;
  logic            cond;
  logic [CW-1:0]   tgt;
  logic [CW:0]     cnt_inc;
  logic            reach;
  logic [CW-1:0]   cnt_sat;

  function automatic logic ch_hit(
    input logic [3:0]   op,
    input logic [W-1:0] p,
    input logic [W-1:0] q,
    input logic [W-1:0] a,
    input logic         pv
  );
    logic r;
    r = 1'b0;
    case (op)
      4'd1:    r = pv && (p > q);
      4'd2:    r = pv && (p < q);
      4'd3:    r = pv && (p != q);
      4'd4:    r = p > a;
      4'd5:    r = p < a;
      4'd6:    r = p >= a;
      4'd7:    r = p <= a;
      4'd8:    r = p == a;
      4'd9:    r = p != a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Per-channel enable and compare result.
  always_comb begin
    en  = '0;
    hit = '0;
    for (int i = 0; i < N; i++) begin
      en[i]  = (bus.ops[i*4 +: 4] >= 4'd1) &&
               (bus.ops[i*4 +: 4] <= 4'd9);
      hit[i] = ch_hit(bus.ops[i*4 +: 4],
                      bus.probes[i*W +: W],
                      prev[i*W +: W],
                      bus.args[i*W +: W],
                      prev_valid);
    end
  end

  // Combine enabled channels; nothing enabled never qualifies.
  always_comb begin
    cond = 1'b0;
    if (|en) begin
      if (bus.mode) cond = &(hit | ~en);
      else          cond = |(hit & en);
    end
  end

  // Target of zero is treated as one; compare one bit wider
  // so a saturated count still reaches any target.
  always_comb begin
    tgt = bus.count_target;
    if (tgt == '0) tgt = {{(CW-1){1'b0}}, 1'b1};
    cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    reach   = cnt_inc >= {1'b0, tgt};
    cnt_sat = (&cnt) ? cnt : cnt_inc[CW-1:0];
  end

  // Previous-sample registers for the edge-style ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev       <= bus.probes;
      prev_valid <= 1'b1;
    end
  end

  // Sequencer FSM with registered fire pulse and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trig_q <= 1'b0;
      cnt    <= '0;
    end else begin
      trig_q <= 1'b0;
      if (bus.disarm) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.arm) begin
              state <= ARMED;
              cnt   <= '0;
            end
          end
          ARMED: begin
            if (bus.arm) begin
              cnt <= '0;
            end else if (cond) begin
              cnt <= cnt_sat;
              if (reach) begin
                state  <= FIRED;
                trig_q <= 1'b1;
              end
            end
          end
          FIRED: begin
            if (bus.arm) begin
              state <= ARMED;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trig      = trig_q;
  assign bus.armed     = (state == ARMED);
  assign bus.triggered = (state == FIRED);
  assign bus.hit_count = cnt;

endmodule

// File: tb/tb_trigger_seq.sv
// Directed-vector bench for trigger_seq with
// hand-computed expectations.
module tb_trigger_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  trigger_seq_if #(
    .INPUT_WIDTH(W),
    .NUM_PROBES(N),
    .COUNT_WIDTH(CW)
  ) bus ();

  trigger_seq #(
    .INPUT_WIDTH(W),
    .NUM_PROBES(N),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(
    input int         ch,
    input logic [3:0] op,
    input logic [7:0] arg
  );
    bus.ops[ch*4 +: 4]  = op;
    bus.args[ch*W +: W] = arg;
  endtask

  task automatic set_p(input int ch, input logic [7:0] v);
    bus.probes[ch*W +: W] = v;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic        t,
    input logic        a,
    input logic        f,
    input logic [15:0] h
  );
    check({tag, ".trig"}, 32'(bus.trig), 32'(t));
    check({tag, ".armed"}, 32'(bus.armed), 32'(a));
    check({tag, ".trgd"}, 32'(bus.triggered), 32'(f));
    check({tag, ".hits"}, 32'(bus.hit_count), 32'(h));
  endtask

  logic [15:0] pat [5];
  logic [15:0] exp_h [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.probes = '0;
    bus.ops = '0;
    bus.args = '0;
    bus.mode = 1'b0;
    bus.count_target = 16'd1;
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    repeat (2) tick();
    chk_out("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // EQ single fire
    set_ch(0, 4'd8, 8'h5A);
    pulse_arm();
    chk_out("eq_arm", 0, 1, 0, 0);
    set_p(0, 8'h5A);
    tick();
    chk_out("eq_fire", 1, 0, 1, 1);
    tick();
    chk_out("eq_after", 0, 0, 1, 1);

    // AND mode GT + FALLING
    bus.mode = 1'b1;
    set_ch(0, 4'd4, 8'h10);
    set_ch(1, 4'd2, 8'h00);
    set_p(0, 8'h20);
    set_p(1, 8'h08);
    pulse_arm();
    set_p(1, 8'h03);
    tick();
    chk_out("and_fire", 1, 0, 1, 1);
    set_p(0, 8'h10);
    set_p(1, 8'h08);
    pulse_arm();
    set_p(1, 8'h03);
    tick();
    chk_out("and_nofire", 0, 1, 0, 0);

    // count to 3, non-consecutive
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;
    bus.mode = 1'b0;
    set_ch(0, 4'd8, 8'h01);
    set_ch(1, 4'd0, 8'h00);
    set_p(0, 8'h00);
    set_p(1, 8'h00);
    bus.count_target = 16'd3;
    pulse_arm();
    pat[0] = 16'd1; pat[1] = 16'd0; pat[2] = 16'd1;
    pat[3] = 16'd0; pat[4] = 16'd1;
    exp_h[0] = 16'd1; exp_h[1] = 16'd1; exp_h[2] = 16'd2;
    exp_h[3] = 16'd2; exp_h[4] = 16'd3;
    for (int i = 0; i < 5; i++) begin
      set_p(0, pat[i][7:0]);
      tick();
      check("cnt3.hits", 32'(bus.hit_count), 32'(exp_h[i]));
      check("cnt3.trig", 32'(bus.trig), (i == 4) ? 1 : 0);
    end

    // target lowered while armed
    bus.count_target = 16'd5;
    set_p(0, 8'h00);
    pulse_arm();
    set_p(0, 8'h01);
    tick();
    tick();
    chk_out("tchg_two", 0, 1, 0, 2);
    bus.count_target = 16'd2;
    set_p(0, 8'h00);
    tick();
    chk_out("tchg_idle", 0, 1, 0, 2);
    set_p(0, 8'h01);
    tick();
    chk_out("tchg_fire", 1, 0, 1, 3);

    // target zero acts as one
    bus.count_target = 16'd0;
    set_p(0, 8'h00);
    pulse_arm();
    set_p(0, 8'h01);
    tick();
    chk_out("tgt0", 1, 0, 1, 1);

    // all channels disabled
    bus.ops = '0;
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      bus.probes = 32'($urandom);
      tick();
      check("dis.trig", 32'(bus.trig), 0);
    end
    chk_out("dis_end", 0, 1, 0, 0);

    // RISING after reset
    rst_n = 1'b0;
    #1;
    bus.ops = '0;
    bus.probes = '0;
    set_ch(0, 4'd1, 8'h00);
    set_p(0, 8'hFF);
    bus.count_target = 16'd1;
    rst_n = 1'b1;
    pulse_arm();
    chk_out("rise_arm", 0, 1, 0, 0);
    tick();
    chk_out("rise_same", 0, 1, 0, 0);
    set_p(0, 8'h00);
    tick();
    chk_out("rise_fall", 0, 1, 0, 0);
    set_p(0, 8'h01);
    tick();
    chk_out("rise_hit", 1, 0, 1, 1);

    // arm and disarm together
    bus.arm = 1'b1;
    bus.disarm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.disarm = 1'b0;
    chk_out("armdis", 0, 0, 0, 1);

    // reset aborts an armed sequence
    set_ch(0, 4'd8, 8'h01);
    bus.count_target = 16'd3;
    set_p(0, 8'h00);
    pulse_arm();
    set_p(0, 8'h01);
    tick();
    chk_out("pre_rst", 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0);
    tick();
    chk_out("held_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 0, 0, 0, 0);

    // arm from FIRED restarts
    bus.count_target = 16'd1;
    set_p(0, 8'h00);
    pulse_arm();
    set_p(0, 8'h01);
    tick();
    chk_out("fire2", 1, 0, 1, 1);
    set_p(0, 8'h00);
    pulse_arm();
    chk_out("rearm", 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
